// File: rtl/mac_rx_dispatch.sv
// Receive-side frame dispatcher: classifies each parsed Ethernet header and
// steers the following 128-bit payload to the IP or ARP consumer, or sinks it.
// Payload steering is combinational (zero latency) with full backpressure.
module mac_rx_dispatch (
    input  logic         wClk,
    input  logic         wRst_n,
    input  logic [47:0]  bLocalMac,
    input  logic         wPromisc,
    input  logic         wHdr_in_valid,
    output logic         wHdr_in_ready,
    input  logic [47:0]  bHdr_in_DstMacAddr,
    input  logic [47:0]  bHdr_in_SrcMacAddr,
    input  logic [15:0]  bHdr_in_FrameType,
    input  logic         wData_in_valid,
    output logic         wData_in_ready,
    input  logic [127:0] bData_in_data,
    input  logic [15:0]  bData_in_keep,
    input  logic         wData_in_last,
    output logic         wIp_out_valid,
    input  logic         wIp_out_ready,
    output logic [127:0] bIp_out_data,
    output logic [15:0]  bIp_out_keep,
    output logic         wIp_out_last,
    output logic         wArp_out_valid,
    input  logic         wArp_out_ready,
    output logic [127:0] bArp_out_data,
    output logic [15:0]  bArp_out_keep,
    output logic         wArp_out_last,
    output logic [47:0]  bRx_SrcMacAddr,
    output logic [15:0]  bDropCnt
);

    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [47:0] MAC_BCAST    = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FWD_IP  = 2'd1,
        ST_FWD_ARP = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        hdr_rdy_q, hdr_rdy_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        hdr_hs;
    logic        data_rdy;
    logic        last_hs;
    logic        addr_match;
    state_t      hdr_route;

    assign hdr_hs  = wHdr_in_valid & hdr_rdy_q;
    assign last_hs = wData_in_valid & data_rdy & wData_in_last;

    // Classify the presented header: address filter first, then EtherType.
    always_comb begin
        addr_match = wPromisc | (bHdr_in_DstMacAddr == bLocalMac) |
                     (bHdr_in_DstMacAddr == MAC_BCAST);
        hdr_route  = ST_DROP;
        if (addr_match && (bHdr_in_FrameType == ETH_TYPE_IP)) begin
            hdr_route = ST_FWD_IP;
        end else if (addr_match && (bHdr_in_FrameType == ETH_TYPE_ARP)) begin
            hdr_route = ST_FWD_ARP;
        end
    end

    // Next-state, header-ready, source-MAC capture and drop-counter updates.
    always_comb begin
        state_d    = state_q;
        hdr_rdy_d  = hdr_rdy_q;
        src_mac_d  = src_mac_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Ready rises on the first edge out of reset and stays up
                // until a header is taken.
                hdr_rdy_d = 1'b1;
                if (hdr_hs) begin
                    hdr_rdy_d = 1'b0;
                    src_mac_d = bHdr_in_SrcMacAddr;
                    state_d   = hdr_route;
                end
            end
            ST_FWD_IP, ST_FWD_ARP, ST_DROP: begin
                if (last_hs) begin
                    state_d   = ST_IDLE;
                    hdr_rdy_d = 1'b1;
                    if ((state_q == ST_DROP) && (drop_cnt_q != 16'hFFFF)) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                hdr_rdy_d = 1'b0;
            end
        endcase
    end

    // Control state registers; reset aborts any frame in flight.
    always_ff @(posedge wClk or negedge wRst_n) begin
        if (!wRst_n) begin
            state_q    <= ST_IDLE;
            hdr_rdy_q  <= 1'b0;
            src_mac_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hdr_rdy_q  <= hdr_rdy_d;
            src_mac_q  <= src_mac_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Combinational payload steering; the unselected port is held at zero.
    always_comb begin
        data_rdy       = 1'b0;
        wIp_out_valid  = 1'b0;
        bIp_out_data   = '0;
        bIp_out_keep   = '0;
        wIp_out_last   = 1'b0;
        wArp_out_valid = 1'b0;
        bArp_out_data  = '0;
        bArp_out_keep  = '0;
        wArp_out_last  = 1'b0;
        case (state_q)
            ST_FWD_IP: begin
                data_rdy      = wIp_out_ready;
                wIp_out_valid = wData_in_valid;
                bIp_out_data  = bData_in_data;
                bIp_out_keep  = bData_in_keep;
                wIp_out_last  = wData_in_last;
            end
            ST_FWD_ARP: begin
                data_rdy       = wArp_out_ready;
                wArp_out_valid = wData_in_valid;
                bArp_out_data  = bData_in_data;
                bArp_out_keep  = bData_in_keep;
                wArp_out_last  = wData_in_last;
            end
            ST_DROP: begin
                data_rdy = 1'b1;
            end
            default: begin
                data_rdy = 1'b0;
            end
        endcase
    end

    assign wData_in_ready = data_rdy;
    assign wHdr_in_ready  = hdr_rdy_q;
    assign bRx_SrcMacAddr = src_mac_q;
    assign bDropCnt       = drop_cnt_q;

endmodule

// File: tb/tb_mac_rx_dispatch.sv
// Self-checking bench for mac_rx_dispatch: directed frames plus randomized
// traffic, compared against a frame-level routing model with beat queues.
module tb_mac_rx_dispatch;

    logic         wClk = 1'b0;
    logic         wRst_n;
    logic [47:0]  bLocalMac;
    logic         wPromisc;
    logic         wHdr_in_valid;
    logic         wHdr_in_ready;
    logic [47:0]  bHdr_in_DstMacAddr;
    logic [47:0]  bHdr_in_SrcMacAddr;
    logic [15:0]  bHdr_in_FrameType;
    logic         wData_in_valid;
    logic         wData_in_ready;
    logic [127:0] bData_in_data;
    logic [15:0]  bData_in_keep;
    logic         wData_in_last;
    logic         wIp_out_valid;
    logic         wIp_out_ready;
    logic [127:0] bIp_out_data;
    logic [15:0]  bIp_out_keep;
    logic         wIp_out_last;
    logic         wArp_out_valid;
    logic         wArp_out_ready;
    logic [127:0] bArp_out_data;
    logic [15:0]  bArp_out_keep;
    logic         wArp_out_last;
    logic [47:0]  bRx_SrcMacAddr;
    logic [15:0]  bDropCnt;

    always #5 wClk = ~wClk;

    mac_rx_dispatch dut (
        .wClk               (wClk),
        .wRst_n             (wRst_n),
        .bLocalMac          (bLocalMac),
        .wPromisc           (wPromisc),
        .wHdr_in_valid      (wHdr_in_valid),
        .wHdr_in_ready      (wHdr_in_ready),
        .bHdr_in_DstMacAddr (bHdr_in_DstMacAddr),
        .bHdr_in_SrcMacAddr (bHdr_in_SrcMacAddr),
        .bHdr_in_FrameType  (bHdr_in_FrameType),
        .wData_in_valid     (wData_in_valid),
        .wData_in_ready     (wData_in_ready),
        .bData_in_data      (bData_in_data),
        .bData_in_keep      (bData_in_keep),
        .wData_in_last      (wData_in_last),
        .wIp_out_valid      (wIp_out_valid),
        .wIp_out_ready      (wIp_out_ready),
        .bIp_out_data       (bIp_out_data),
        .bIp_out_keep       (bIp_out_keep),
        .wIp_out_last       (wIp_out_last),
        .wArp_out_valid     (wArp_out_valid),
        .wArp_out_ready     (wArp_out_ready),
        .bArp_out_data      (bArp_out_data),
        .bArp_out_keep      (bArp_out_keep),
        .wArp_out_last      (wArp_out_last),
        .bRx_SrcMacAddr     (bRx_SrcMacAddr),
        .bDropCnt           (bDropCnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0]  m_drop = 16'd0;
    logic         expect_immediate = 1'b0;
    logic [159:0] ip_exp[$];
    logic [159:0] arp_exp[$];
    logic [159:0] ip_got[$];
    logic [159:0] arp_got[$];

    task automatic chk_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [159:0] pvec(input logic v, input logic last,
                                          input logic [15:0] keep, input logic [127:0] data);
        return {14'd0, v, last, keep, data};
    endfunction

    // 0 = discard, 1 = IP consumer, 2 = ARP consumer
    function automatic int route(input logic [47:0] dst, input logic [15:0] ty,
                                 input logic [47:0] local_mac, input logic promisc);
        bit for_us;
        for_us = promisc || (dst == local_mac) || (dst == 48'hFFFF_FFFF_FFFF);
        if (!for_us)           return 0;
        if (ty == 16'h0800)    return 1;
        if (ty == 16'h0806)    return 2;
        return 0;
    endfunction

    // Record every beat actually transferred on each output port.
    always @(negedge wClk) begin
        if (wRst_n) begin
            if (wIp_out_valid && wIp_out_ready)
                ip_got.push_back(pvec(1'b1, wIp_out_last, bIp_out_keep, bIp_out_data));
            if (wArp_out_valid && wArp_out_ready)
                arp_got.push_back(pvec(1'b1, wArp_out_last, bArp_out_keep, bArp_out_data));
        end
    end

    task automatic compare_queues();
        chk_eq("ip_beat_count", 160'(ip_got.size()), 160'(ip_exp.size()));
        chk_eq("arp_beat_count", 160'(arp_got.size()), 160'(arp_exp.size()));
        for (int i = 0; i < ip_exp.size() && i < ip_got.size(); i++)
            chk_eq("ip_beat", ip_got[i], ip_exp[i]);
        for (int i = 0; i < arp_exp.size() && i < arp_got.size(); i++)
            chk_eq("arp_beat", arp_got[i], arp_exp[i]);
        ip_got.delete(); ip_exp.delete(); arp_got.delete(); arp_exp.delete();
    endtask

    // rdy_mode: 0 random valid/ready, 1 always ready, 2 ready pattern 1,0,0
    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] ty,
                              input int nbeats, input int rdy_mode, input logic hold_next,
                              input logic [47:0] ndst, input logic [47:0] nsrc, input logic [15:0] nty);
        int   r, waits, beat, cyc;
        logic rdy, exp_rdy;
        r = route(dst, ty, bLocalMac, wPromisc);
        bHdr_in_DstMacAddr = dst;
        bHdr_in_SrcMacAddr = src;
        bHdr_in_FrameType  = ty;
        wHdr_in_valid      = 1'b1;
        wData_in_valid     = 1'b1;
        bData_in_data      = {$urandom, $urandom, $urandom, $urandom};
        wData_in_last      = 1'b0;
        waits = 0;
        do begin
            @(negedge wClk);
            chk_eq("idle_data_ready", 160'(wData_in_ready), 160'(0));
            chk_eq("idle_ip_out", pvec(wIp_out_valid, wIp_out_last, bIp_out_keep, bIp_out_data), 160'(0));
            chk_eq("idle_arp_out", pvec(wArp_out_valid, wArp_out_last, bArp_out_keep, bArp_out_data), 160'(0));
            if (!wHdr_in_ready) waits++;
        end while (!wHdr_in_ready && waits < 20);
        if (!wHdr_in_ready) chk_eq("hdr_ready_timeout", 160'(wHdr_in_ready), 160'(1));
        if (expect_immediate) chk_eq("hdr_gap_cycles", 160'(waits), 160'(0));
        @(posedge wClk); #1;
        wHdr_in_valid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < nbeats && cyc < 400) begin
            bData_in_data  = {$urandom, $urandom, $urandom, $urandom};
            wData_in_last  = (beat == nbeats - 1);
            bData_in_keep  = wData_in_last ? 16'($urandom) : 16'hFFFF;
            wData_in_valid = (rdy_mode != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            case (rdy_mode)
                1:       rdy = 1'b1;
                2:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            wIp_out_ready  = rdy;
            wArp_out_ready = rdy;
            if (hold_next) begin
                bHdr_in_DstMacAddr = ndst;
                bHdr_in_SrcMacAddr = nsrc;
                bHdr_in_FrameType  = nty;
                wHdr_in_valid      = 1'b1;
            end
            @(negedge wClk);
            exp_rdy = (r == 0) ? 1'b1 : rdy;
            chk_eq("data_ready", 160'(wData_in_ready), 160'(exp_rdy));
            chk_eq("hdr_ready_busy", 160'(wHdr_in_ready), 160'(0));
            chk_eq("ip_out", pvec(wIp_out_valid, wIp_out_last, bIp_out_keep, bIp_out_data),
                   (r == 1) ? pvec(wData_in_valid, wData_in_last, bData_in_keep, bData_in_data) : 160'(0));
            chk_eq("arp_out", pvec(wArp_out_valid, wArp_out_last, bArp_out_keep, bArp_out_data),
                   (r == 2) ? pvec(wData_in_valid, wData_in_last, bData_in_keep, bData_in_data) : 160'(0));
            if (wData_in_valid && exp_rdy) begin
                if (r == 1) ip_exp.push_back(pvec(1'b1, wData_in_last, bData_in_keep, bData_in_data));
                if (r == 2) arp_exp.push_back(pvec(1'b1, wData_in_last, bData_in_keep, bData_in_data));
                beat++;
            end
            @(posedge wClk); #1;
            cyc++;
        end
        wData_in_valid = 1'b0;
        wData_in_last  = 1'b0;
        if (beat < nbeats) chk_eq("payload_timeout", 160'(beat), 160'(nbeats));
        if (r == 0 && m_drop != 16'hFFFF) m_drop++;
        chk_eq("hdr_ready_after_last", 160'(wHdr_in_ready), 160'(1));
        chk_eq("rx_src_mac", 160'(bRx_SrcMacAddr), 160'(src));
        chk_eq("drop_cnt", 160'(bDropCnt), 160'(m_drop));
        compare_queues();
        expect_immediate = hold_next;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_hdr_ready"}, 160'(wHdr_in_ready), 160'(0));
        chk_eq({tag, "_data_ready"}, 160'(wData_in_ready), 160'(0));
        chk_eq({tag, "_ip_out"}, pvec(wIp_out_valid, wIp_out_last, bIp_out_keep, bIp_out_data), 160'(0));
        chk_eq({tag, "_arp_out"}, pvec(wArp_out_valid, wArp_out_last, bArp_out_keep, bArp_out_data), 160'(0));
        chk_eq({tag, "_src_mac"}, 160'(bRx_SrcMacAddr), 160'(0));
        chk_eq({tag, "_drop_cnt"}, 160'(bDropCnt), 160'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] dst, lm;
        logic [15:0] ty;
        wRst_n = 1'b0;
        bLocalMac = 48'h0123_4567_89AB;
        wPromisc = 1'b0;
        wHdr_in_valid = 1'b0;
        bHdr_in_DstMacAddr = '0;
        bHdr_in_SrcMacAddr = '0;
        bHdr_in_FrameType = '0;
        wData_in_valid = 1'b0;
        bData_in_data = '0;
        bData_in_keep = '0;
        wData_in_last = 1'b0;
        wIp_out_ready = 1'b1;
        wArp_out_ready = 1'b1;

        #12;
        check_reset_outputs("reset");
        @(posedge wClk); #1;
        wRst_n = 1'b1;
        chk_eq("hdr_ready_before_edge", 160'(wHdr_in_ready), 160'(0));
        @(posedge wClk); #1;
        chk_eq("hdr_ready_first_edge", 160'(wHdr_in_ready), 160'(1));

        // IP frame to local MAC, 12 beats
        send_frame(48'h0123_4567_89AB, 48'h9876_5432_10AA, 16'h0800, 12, 1, 1'b0, '0, '0, '0);
        // ARP broadcast, 3 beats
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0A0B_0C0D_0E0F, 16'h0806, 3, 1, 1'b0, '0, '0, '0);
        // MAC mismatch dropped, then accepted in promiscuous mode
        send_frame(48'h1111_1111_1111, 48'h2222_2222_2222, 16'h0800, 5, 1, 1'b0, '0, '0, '0);
        wPromisc = 1'b1;
        send_frame(48'h1111_1111_1111, 48'h3333_3333_3333, 16'h0800, 5, 1, 1'b0, '0, '0, '0);
        wPromisc = 1'b0;
        // Unknown EtherType to local MAC
        send_frame(48'h0123_4567_89AB, 48'h4444_4444_4444, 16'h86DD, 2, 1, 1'b0, '0, '0, '0);
        // Single-beat frames, forwarded and dropped
        send_frame(48'h0123_4567_89AB, 48'h5555_5555_5555, 16'h0800, 1, 1, 1'b0, '0, '0, '0);
        send_frame(48'h0123_4567_89AB, 48'h6666_6666_6666, 16'h1234, 1, 1, 1'b0, '0, '0, '0);

        // Backpressure with the next header waiting throughout the frame
        send_frame(48'h0123_4567_89AB, 48'h7777_7777_7777, 16'h0800, 8, 2, 1'b1,
                   48'hFFFF_FFFF_FFFF, 48'h8888_8888_8888, 16'h0800);
        send_frame(48'hFFFF_FFFF_FFFF, 48'h8888_8888_8888, 16'h0800, 4, 2, 1'b0, '0, '0, '0);

        // Start the counter just below its ceiling, then drop three frames
        force dut.drop_cnt_q = 16'hFFFD;
        #1;
        release dut.drop_cnt_q;
        m_drop = 16'hFFFD;
        for (int i = 0; i < 3; i++)
            send_frame(48'h0123_4567_89AB, 48'h9999_9999_9999, 16'h86DD, 2, 1, 1'b0, '0, '0, '0);

        // Reset asserted during beat 5 of a 10-beat IP frame
        bHdr_in_DstMacAddr = 48'h0123_4567_89AB;
        bHdr_in_SrcMacAddr = 48'hABCD_EF01_2345;
        bHdr_in_FrameType  = 16'h0800;
        wHdr_in_valid = 1'b1;
        @(negedge wClk);
        chk_eq("rst_frame_hdr_ready", 160'(wHdr_in_ready), 160'(1));
        @(posedge wClk); #1;
        wHdr_in_valid = 1'b0;
        wIp_out_ready = 1'b1;
        wData_in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bData_in_data = {$urandom, $urandom, $urandom, $urandom};
            bData_in_keep = 16'hFFFF;
            wData_in_last = 1'b0;
            ip_exp.push_back(pvec(1'b1, 1'b0, bData_in_keep, bData_in_data));
            @(posedge wClk); #1;
        end
        bData_in_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        wRst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        compare_queues();
        m_drop = 16'd0;
        expect_immediate = 1'b0;
        wData_in_valid = 1'b0;
        @(posedge wClk); #1;
        wRst_n = 1'b1;
        send_frame(48'h0123_4567_89AB, 48'h1357_9BDF_2468, 16'h0800, 6, 1, 1'b0, '0, '0, '0);

        // Randomized traffic
        for (int f = 0; f < 40; f++) begin
            lm = 48'({$urandom, $urandom});
            bLocalMac = lm;
            wPromisc = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       dst = lm;
                1:       dst = 48'hFFFF_FFFF_FFFF;
                default: dst = 48'({$urandom, $urandom});
            endcase
            case ($urandom_range(0, 3))
                0:       ty = 16'h0800;
                1:       ty = 16'h0806;
                2:       ty = 16'h86DD;
                default: ty = 16'($urandom);
            endcase
            send_frame(dst, 48'({$urandom, $urandom}), ty, int'($urandom_range(1, 6)), 0, 1'b0,
                       '0, '0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
